message_readout: RTL and testbench
==================================

// Module: message_readout
// PURPOSE
//  Reader for the decrypted-message RAM (d_memory) filled by the RC4 decrypt
//  datapath. Once the datapath reports done, this block reads the message
//  bytes from address 0 upward and streams them to a downstream consumer
//  (LCD/HEX/UART driver) over a valid/ready handshake. It also flags any byte
//  outside the legal plaintext set {0x61..0x7A, 0x20}. It uses the same
//  start/done flag handshake as the other memory engines.
// PARAMETERS
//  ADDR_WIDTH    8   width of d_memory address bus
//  MSG_LEN       32  number of bytes to stream (1..2**ADDR_WIDTH)
//  READ_LATENCY  1   cycles from address registered at RAM to q valid (>=1)
// PORTS
//  clk              in   1           system clock, all logic on posedge
//  reset            in   1           asynchronous, active-high reset
//  start_flag       in   1           level; begin a readout when high in IDLE
//  done_flag        out  1           high in DONE state only
//  address          out  ADDR_WIDTH  d_memory read address (wren never driven)
//  data_out         in   8           d_memory q
//  byte_out         out  8           current message byte (registered)
//  byte_valid       out  1           byte_out holds a byte for the consumer
//  byte_ready       in   1           consumer accepts byte_out this cycle
//  byte_index       out  ADDR_WIDTH  index of byte currently on byte_out
//  invalid_char_flag out 1           sticky: some streamed byte was illegal
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, address=0, byte_out=0, byte_valid=0,
//   byte_index=0, invalid_char_flag=0, done_flag=0, wait counter=0.
//  States: IDLE, ISSUE, WAIT, PRESENT, DONE.
//   IDLE: if start_flag -> ISSUE; clear index, invalid_char_flag, address=0.
//   ISSUE: 1 cycle; address=index (held constant through WAIT) -> WAIT.
//   WAIT: READ_LATENCY cycles (counter). On the final WAIT edge register
//    data_out into byte_out. Set invalid_char_flag if the byte is not in
//    0x61..0x7A and is not 0x20. -> PRESENT.
//   PRESENT: byte_valid=1; byte_out and byte_index stable until accepted.
//    Transfer = byte_valid && byte_ready at a posedge. On transfer:
//    if index==MSG_LEN-1 -> DONE, else index+1 and -> ISSUE.
//    No transfer -> stay in PRESENT; the byte stays unchanged.
//   DONE: done_flag=1, byte_valid=0. Stay while start_flag is high.
//    -> IDLE when start_flag is low (4-phase handshake).
//  Timing: with byte_ready tied high and READ_LATENCY=1, there is one byte
//   every 3 cycles. First byte_valid is 3 cycles after start is sampled.
//  byte_valid is low in every state except PRESENT. byte_ready is ignored
//   outside PRESENT.
//  Index arithmetic is unsigned ADDR_WIDTH. It never wraps because it stops
//   at MSG_LEN-1. MSG_LEN=2**ADDR_WIDTH is legal; the last index is all ones.
//  invalid_char_flag stays sticky through DONE. It clears only on reset or
//   on a new start taken in IDLE.
//  start_flag dropping mid-readout has no effect. Only reset aborts a readout.
// TESTING
//  1. Preload d_mem with "attack at dawn" padded with 0x20 to 32 bytes; ready=1,
//     start=1 -> 32 bytes in address order, byte i valid at cycle 3+3i;
//     done_flag=1 after byte 31; invalid_char_flag=0.
//  2. Same image; ready toggles 1 cycle on, 3 off -> byte_out and byte_index
//     stay stable while valid&&!ready; no byte dropped or duplicated.
//  3. Byte 17 = 0x41 ('A') -> all 32 bytes still streamed; invalid_char_flag
//     rises on the edge that captures byte 17 and stays high in DONE.
//  4. Assert reset while PRESENT at index 9 -> all outputs are 0 immediately
//     (async); after release with start=1, streaming restarts at index 0.
//  5. In DONE, hold start high 10 cycles -> stays DONE. Drop start -> IDLE.
//     Raise again -> second full readout with the flag cleared.
//  6. READ_LATENCY=2 and MSG_LEN=256 -> 4 cycles per byte with ready=1;
//     index reaches 255 and then DONE with no wrap to 0.

Source files
------------

// File: rtl/message_readout.sv
// Streams MSG_LEN bytes of d_memory from address 0 to a valid/ready consumer and flags illegal chars.
// Latency: 2+READ_LATENCY cycles per byte with ready high; byte_out/byte_index hold while valid && !ready.
module message_readout #(
  parameter int ADDR_WIDTH   = 8,
  parameter int MSG_LEN      = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_flag,
  output logic                  done_flag,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [7:0]            data_out,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] byte_index,
  output logic                  invalid_char_flag
);

  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(MSG_LEN - 1);
  localparam logic [CW-1:0]         LAST_WAIT = CW'(READ_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [7:0]            byte_q, byte_d;
  logic                  inv_q, inv_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic transfer;
  logic wait_last;
  logic byte_legal;
  logic last_byte;

  assign transfer   = (state_q == PRESENT) && byte_ready;
  assign wait_last  = (state_q == WAIT) && (cnt_q == LAST_WAIT);
  assign last_byte  = (idx_q == LAST_IDX);
  assign byte_legal = ((data_out >= 8'h61) && (data_out <= 8'h7A)) || (data_out == 8'h20);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_flag) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (wait_last) state_d = PRESENT;
      PRESENT: if (transfer) state_d = last_byte ? DONE : ISSUE;
      DONE:    if (!start_flag) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_valid = (state_q == PRESENT);
    done_flag  = (state_q == DONE);
  end

  // The read address is loaded on entry to ISSUE so the RAM registers it at the end of ISSUE.
  always_comb begin
    addr_d = addr_q;
    idx_d  = idx_q;
    byte_d = byte_q;
    inv_d  = inv_q;
    cnt_d  = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_flag) begin
          idx_d  = '0;
          addr_d = '0;
          inv_d  = 1'b0;
          cnt_d  = '0;
        end
      end
      ISSUE: cnt_d = '0;
      WAIT: begin
        if (wait_last) begin
          cnt_d  = '0;
          byte_d = data_out;
          if (!byte_legal) inv_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESENT: begin
        if (transfer && !last_byte) begin
          idx_d  = idx_q + 1'b1;
          addr_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      idx_q  <= '0;
      byte_q <= '0;
      inv_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      idx_q  <= idx_d;
      byte_q <= byte_d;
      inv_q  <= inv_d;
      cnt_q  <= cnt_d;
    end
  end

  assign address           = addr_q;
  assign byte_out          = byte_q;
  assign byte_index        = idx_q;
  assign invalid_char_flag = inv_q;

endmodule

// File: tb/tb_message_readout.sv
// Directed bench: 32-byte readout at READ_LATENCY=1 (instance a) and 256-byte readout at READ_LATENCY=2 (instance b).
module tb_message_readout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic       a_start, a_done, a_valid, a_ready, a_inv;
  logic [7:0] a_addr, a_q, a_byte, a_idx;
  logic [7:0] mem_a [0:255];
  logic [7:0] img   [0:31];

  logic       b_start, b_done, b_valid, b_ready, b_inv;
  logic [7:0] b_addr, b_q, b_q1, b_byte, b_idx;
  logic [7:0] mem_b [0:255];

  always @(posedge clk) a_q <= mem_a[a_addr];
  always @(posedge clk) begin
    b_q1 <= mem_b[b_addr];
    b_q  <= b_q1;
  end

  message_readout #(.ADDR_WIDTH(8), .MSG_LEN(32), .READ_LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset), .start_flag(a_start), .done_flag(a_done),
    .address(a_addr), .data_out(a_q), .byte_out(a_byte), .byte_valid(a_valid),
    .byte_ready(a_ready), .byte_index(a_idx), .invalid_char_flag(a_inv)
  );

  message_readout #(.ADDR_WIDTH(8), .MSG_LEN(256), .READ_LATENCY(2)) u_dut_b (
    .clk(clk), .reset(reset), .start_flag(b_start), .done_flag(b_done),
    .address(b_addr), .data_out(b_q), .byte_out(b_byte), .byte_valid(b_valid),
    .byte_ready(b_ready), .byte_index(b_idx), .invalid_char_flag(b_inv)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high with cycle-exact timing; mode 1: ready high 1 cycle in 4.
  task automatic stream_a(input int mode, input int bad_idx, input int drop_at);
    int         cyc;
    int         got;
    logic       pv, pr, exp_inv;
    logic [7:0] pb, pi;
    cyc = 0; got = 0; pv = 1'b0; pr = 1'b0; pb = '0; pi = '0;
    a_start = 1'b1;
    while (got < 32 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (cyc == drop_at) a_start = 1'b0;
      if (pv && !pr) begin
        chk("hold_vld", 32'(a_valid), 32'd1);
        chk("hold_byte", 32'(a_byte), 32'(pb));
        chk("hold_idx", 32'(a_idx), 32'(pi));
      end
      exp_inv = (bad_idx >= 0) && ((got > bad_idx) || (got == bad_idx && a_valid));
      chk("inv_flag", 32'(a_inv), 32'(exp_inv));
      a_ready = (mode == 0) ? 1'b1 : ((cyc % 4) == 0);
      if (a_valid && a_ready) begin
        chk("byte", 32'(a_byte), 32'(img[got]));
        chk("idx", 32'(a_idx), 32'(got));
        if (mode == 0) chk("accept_cyc", 32'(cyc), 32'(3 + 3 * got));
        got++;
      end
      pv = a_valid; pr = a_ready; pb = a_byte; pi = a_idx;
    end
    chk("all_bytes", 32'(got), 32'd32);
    @(negedge clk);
    chk("done", 32'(a_done), 32'd1);
    chk("done_vld", 32'(a_valid), 32'd0);
    chk("done_inv", 32'(a_inv), 32'(bad_idx >= 0));
  endtask

  initial begin
    string      msg;
    logic [7:0] saved;
    int         cyc, got;
    logic       found;
    msg = "attack at dawn";
    for (int i = 0; i < 32; i++) img[i] = (i < msg.len()) ? msg[i] : 8'h20;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = (i < 32) ? img[i] : 8'h00;
      mem_b[i] = 8'h61 + 8'(i % 26);
    end
    a_start = 1'b0; a_ready = 1'b0; b_start = 1'b0; b_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_vld", 32'(a_valid), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_byte", 32'(a_byte), 32'd0);
    chk("rst_inv", 32'(a_inv), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_vld", 32'(a_valid), 32'd0);

    // Full readout, ready high, then DONE held while start stays high.
    stream_a(0, -1, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_done", 32'(a_done), 32'd1);
    end
    a_start = 1'b0;
    @(negedge clk);
    chk("back_idle", 32'(a_done), 32'd0);

    // Throttled consumer; start drops mid-readout and must be ignored.
    stream_a(1, -1, 5);
    @(negedge clk);
    chk("idle_after_t2", 32'(a_done), 32'd0);

    // Illegal byte 17 sets the sticky flag.
    saved = img[17];
    mem_a[17] = 8'h41; img[17] = 8'h41;
    stream_a(0, 17, 0);
    a_start = 1'b0;
    @(negedge clk);
    chk("inv_sticky_idle", 32'(a_inv), 32'd1);
    mem_a[17] = saved; img[17] = saved;

    // Async reset while presenting index 9, then clean restart from 0.
    a_start = 1'b1; a_ready = 1'b1; found = 1'b0; cyc = 0;
    while (!found && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (a_valid && a_idx == 8'd9) begin
        found = 1'b1;
        a_ready = 1'b0;
      end
    end
    chk("reach_idx9", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_addr", 32'(a_addr), 32'd0);
    chk("arst_byte", 32'(a_byte), 32'd0);
    chk("arst_vld", 32'(a_valid), 32'd0);
    chk("arst_idx", 32'(a_idx), 32'd0);
    chk("arst_done", 32'(a_done), 32'd0);
    chk("arst_inv", 32'(a_inv), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stream_a(0, -1, 0);
    a_start = 1'b0;
    @(negedge clk);

    // 256-byte readout with two-cycle RAM latency: 4 cycles per byte, no index wrap.
    b_start = 1'b1; b_ready = 1'b1; cyc = 0; got = 0;
    while (got < 256 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (b_valid) begin
        chk("b_byte", 32'(b_byte), 32'(8'h61 + 8'(got % 26)));
        chk("b_idx", 32'(b_idx), 32'(got));
        chk("b_accept_cyc", 32'(cyc), 32'(4 + 4 * got));
        got++;
      end
    end
    chk("b_all_bytes", 32'(got), 32'd256);
    @(negedge clk);
    chk("b_done", 32'(b_done), 32'd1);
    chk("b_last_idx", 32'(b_idx), 32'd255);
    chk("b_done_vld", 32'(b_valid), 32'd0);
    chk("b_inv", 32'(b_inv), 32'd0);
    b_start = 1'b0;
    @(negedge clk);
    chk("b_idle", 32'(b_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
